pwr_event_acc: RTL and testbench
================================

Name: pwr_event_acc

Overview:
- Synthesizable per-channel power-event accumulator. It is the consuming side of the gate-level power accounting scheme, where gates signal 0->1 output transitions and each transition carries a weight.
- Samples up to N_CH monitored nets on the clock and adds a programmable weight on every rising edge of a net.
- Streams a consistent snapshot of all counters out over a valid/ready port on request.
- Sits next to the gate netlist under test; its dump stream is read by the bench or a logging block.

Parameters:
- N_CH, 8, number of monitored channels (2..32).
- AW, 3, channel index width; must satisfy 2^AW >= N_CH.
- W_CNT, 16, accumulator width per channel.
- W_WGT, 4, weight width.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  accumulation enable; when 0, edges are tracked but not counted.
- sig_in  in  N_CH  monitored nets; bit i is channel i.
- wgt_we  in  1  weight write strobe.
- wgt_addr  in  AW  channel whose weight is written.
- wgt_data  in  W_WGT  new weight.
- dump_start  in  1  one-cycle request to snapshot and stream all counters.
- clr_on_dump  in  1  sampled with dump_start; 1 = clear live counters at snapshot.
- out_valid  out  1  dump word valid.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- out_chan  out  AW  channel index of the current word.
- out_data  out  W_CNT  snapshot count of that channel.
- out_sat  out  1  channel saturated before the snapshot.
- busy  out  1  dump in progress.

Behaviour:
- Reset values:
  - all counters 0, all sat bits 0, all weights 1.
  - out_valid=0, out_chan=0, out_data=0, out_sat=0, busy=0, FSM=IDLE.
  - edge register loaded with the current sig_in, so a net already high at reset is not counted.
- Edge detection:
  - rise[i] = sig_in[i] & ~sig_q[i]; sig_q <= sig_in every cycle.
  - sig_q updates regardless of enable.
- Accumulation, when enable & rise[i]:
  - cnt[i] <= min(cnt[i] + wgt[i], 2^W_CNT - 1).
  - Sticky sat[i] is set if the true sum exceeds the maximum.
  - A weight of 0 is legal and adds nothing.
- Weight write: wgt[wgt_addr] <= wgt_data.
  - An edge in the same cycle on that channel uses the old weight.
  - wgt_addr >= N_CH is ignored.
- FSM states: IDLE, SEND.
  - IDLE + dump_start at edge t:
    - copy every cnt and sat into the shadow bank;
    - if clr_on_dump, clear cnt and sat (an edge at t then yields cnt = weight, the start of a new epoch);
    - set idx=0, busy=1, go to SEND.
    - The first out_valid is high after edge t, i.e. 1-cycle latency.
  - SEND: out_valid=1, out_chan=idx, out_data=shadow[idx], out_sat=shadow_sat[idx].
    - Outputs are held stable while out_ready=0.
    - On handshake: if idx==N_CH-1, go to IDLE with out_valid=0 and busy=0 next cycle; else idx+1.
    - Back-to-back: one word per cycle with out_ready held high; full dump = N_CH cycles.
  - dump_start while busy is ignored; no queueing.
  - Live accumulation continues during SEND and does not affect shadow values.
- Reset mid-dump: aborts immediately; all outputs return to reset values on the next cycle.
- enable=0 does not block dumps.

Decomposition:
- Package pwr_acc_pkg holds:
  - the FSM state encoding (IDLE, SEND);
  - default weight constants per gate class: WGT_INV, WGT_AND2..WGT_AND5, WGT_OR2..WGT_OR5, WGT_XOR2, WGT_XOR3;
  - the saturating-add width rule, computed at W_CNT+1 bits internally.
- Sub-module pwr_acc_ch holds one channel: edge register, weight register, saturating counter, sat bit. It is instantiated N_CH times.
- The top level holds the shadow bank, dump FSM and output mux.

Test Plan:
- Reset with sig_in=8'hFF, hold 5 cycles, release, dump -> all out_data=0 and out_sat=0.
- Write weight 3 to ch2; toggle sig_in[2] 0->1 four times with enable=1; dump -> ch2 out_data=12, others 0, words in order ch0..ch7.
- W_CNT=4, weight 5 on ch0, 4 rising edges -> out_data=15, out_sat=1. Dump with clr_on_dump=1, then one more edge and a second dump -> out_data=5, out_sat=0.
- Dump with out_ready toggling 1,0,0,1,... -> out_data/out_chan stable while stalled. Exactly N_CH handshakes occur, then busy=0.
- Rising edge on ch1 in the same cycle as dump_start with clr_on_dump=1 -> snapshot ch1 excludes the edge; live ch1 equals its weight after the dump.
- Assert reset while in SEND at idx=3 -> out_valid=0 and busy=0 next cycle. A new dump afterwards starts at ch0 with all counts 0.

Source files
------------

// File: rtl/pwr_acc_pkg.sv
// Shared definitions for the power-event accumulator: dump FSM encoding,
// default per-gate-class weights and the width rule for the saturating add.
package pwr_acc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } acc_state_t;

    // Default switching weights per gate class, roughly tracking output load.
    localparam int WGT_INV  = 1;
    localparam int WGT_AND2 = 2;
    localparam int WGT_AND3 = 3;
    localparam int WGT_AND4 = 4;
    localparam int WGT_AND5 = 5;
    localparam int WGT_OR2  = 2;
    localparam int WGT_OR3  = 3;
    localparam int WGT_OR4  = 4;
    localparam int WGT_OR5  = 5;
    localparam int WGT_XOR2 = 4;
    localparam int WGT_XOR3 = 6;

    // The add is done one bit wider than the counter so the carry-out flags overflow.
    function automatic int sat_sum_width(input int w_cnt);
        return w_cnt + 1;
    endfunction

endpackage

// File: rtl/pwr_acc_ch.sv
// One accumulator channel: rising-edge detector, programmable weight,
// saturating counter and sticky saturation flag.
module pwr_acc_ch
    import pwr_acc_pkg::*;
#(
    parameter int W_CNT = 16,
    parameter int W_WGT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    input  logic             wgt_we,
    input  logic [W_WGT-1:0] wgt_data,
    input  logic             clr,
    output logic [W_CNT-1:0] cnt,
    output logic             sat
);

    localparam int W_SUM = sat_sum_width(W_CNT);

    logic             sig_q;
    logic             rise;
    logic [W_WGT-1:0] wgt;
    logic [W_CNT-1:0] cnt_base;
    logic             sat_base;
    logic [W_SUM-1:0] sum;
    logic             overflow;

    // A clear and an edge in the same cycle start the new epoch at the weight.
    always_comb begin
        rise     = sig_in & ~sig_q;
        cnt_base = clr ? '0 : cnt;
        sat_base = clr ? 1'b0 : sat;
        sum      = W_SUM'(cnt_base) + W_SUM'(wgt);
        overflow = sum[W_SUM-1];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the same-cycle weight write therefore misses this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= sig_in;
            wgt   <= W_WGT'(1);
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            sig_q <= sig_in;
            if (wgt_we) wgt <= wgt_data;
            if (enable && rise) begin
                cnt <= overflow ? '1 : sum[W_CNT-1:0];
                sat <= sat_base | overflow;
            end else begin
                cnt <= cnt_base;
                sat <= sat_base;
            end
        end
    end

endmodule

// File: rtl/pwr_event_acc.sv
// Per-channel power-event accumulator with a snapshot bank streamed out
// over a valid/ready port, one channel per word.
module pwr_event_acc
    import pwr_acc_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int AW    = 3,
    parameter int W_CNT = 16,
    parameter int W_WGT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_CH-1:0]  sig_in,
    input  logic             wgt_we,
    input  logic [AW-1:0]    wgt_addr,
    input  logic [W_WGT-1:0] wgt_data,
    input  logic             dump_start,
    input  logic             clr_on_dump,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_chan,
    output logic [W_CNT-1:0] out_data,
    output logic             out_sat,
    output logic             busy
);

    acc_state_t       state, state_nxt;
    logic [AW-1:0]    idx;
    logic             start_dump;
    logic             last_word;
    logic [W_CNT-1:0] cnt_live   [N_CH];
    logic             sat_live   [N_CH];
    logic [W_CNT-1:0] shadow_cnt [N_CH];
    logic             shadow_sat [N_CH];

    assign start_dump = (state == IDLE) && dump_start;
    assign last_word  = (idx == AW'(N_CH - 1));

    // Weight addresses beyond the last channel match no instance and are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwr_acc_ch #(
            .W_CNT (W_CNT),
            .W_WGT (W_WGT)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .sig_in   (sig_in[i]),
            .wgt_we   (wgt_we && (wgt_addr == AW'(i))),
            .wgt_data (wgt_data),
            .clr      (start_dump && clr_on_dump),
            .cnt      (cnt_live[i]),
            .sat      (sat_live[i])
        );
    end

    // NOTE: the shadow bank is deliberately not reset; it is only visible
    // through the SEND-gated output mux, which is forced to zero otherwise.
    always_ff @(posedge clk) begin
        if (start_dump) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow_cnt[i] <= cnt_live[i];
                shadow_sat[i] <= sat_live[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (dump_start) state_nxt = SEND;
            SEND: if (out_ready && last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || start_dump) begin
            idx <= '0;
        end else if ((state == SEND) && out_ready) begin
            idx <= last_word ? '0 : idx + AW'(1);
        end
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_chan  = '0;
        out_data  = '0;
        out_sat   = 1'b0;
        if (state == SEND) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_chan  = idx;
            out_data  = shadow_cnt[idx];
            out_sat   = shadow_sat[idx];
        end
    end

endmodule

// File: tb/tb_pwr_event_acc.sv
// Directed bench for pwr_event_acc: a default instance and a narrow-counter
// instance share all stimulus so saturation can be observed at W_CNT=4.
module tb_pwr_event_acc;

    localparam int N_CH = 8;
    localparam int AW   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [N_CH-1:0]  sig_in;
    logic             wgt_we;
    logic [AW-1:0]    wgt_addr;
    logic [3:0]       wgt_data;
    logic             dump_start;
    logic             clr_on_dump;
    logic             out_ready;

    logic             out_valid, out_sat, busy;
    logic [AW-1:0]    out_chan;
    logic [15:0]      out_data;
    logic             out_valid4, out_sat4, busy4;
    logic [AW-1:0]    out_chan4;
    logic [3:0]       out_data4;

    int n_vec = 0;
    int n_err = 0;

    int exp_cnt  [N_CH];
    int exp_sat  [N_CH];
    int exp_cnt4 [N_CH];
    int exp_sat4 [N_CH];

    always #5 clk = ~clk;

    pwr_event_acc #(.N_CH(N_CH), .AW(AW), .W_CNT(16), .W_WGT(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .dump_start(dump_start), .clr_on_dump(clr_on_dump),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    pwr_event_acc #(.N_CH(N_CH), .AW(AW), .W_CNT(4), .W_WGT(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .dump_start(dump_start), .clr_on_dump(clr_on_dump),
        .out_valid(out_valid4), .out_ready(out_ready), .out_chan(out_chan4),
        .out_data(out_data4), .out_sat(out_sat4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N_CH; i++) begin
            exp_cnt[i]  = 0;
            exp_sat[i]  = 0;
            exp_cnt4[i] = 0;
            exp_sat4[i] = 0;
        end
    endtask

    task automatic write_wgt(input int ch, input int w);
        wgt_we   = 1'b1;
        wgt_addr = AW'(ch);
        wgt_data = 4'(w);
        tick();
        wgt_we   = 1'b0;
    endtask

    task automatic pulse(input int ch, input int n);
        for (int p = 0; p < n; p++) begin
            sig_in[ch] = 1'b1;
            tick();
            sig_in[ch] = 1'b0;
            tick();
        end
    endtask

    // Full back-to-back dump; words are compared against exp_* on both instances.
    task automatic do_dump(input string tag, input logic clr, input logic [N_CH-1:0] rise_mask);
        sig_in      = sig_in | rise_mask;
        dump_start  = 1'b1;
        clr_on_dump = clr;
        tick();
        dump_start  = 1'b0;
        clr_on_dump = 1'b0;
        check({tag, " latency_valid"}, out_valid, 1);
        check({tag, " busy"}, busy, 1);
        out_ready = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            int wait_cyc = 0;
            while (!out_valid && wait_cyc < 20) begin
                tick();
                wait_cyc++;
            end
            check($sformatf("%s valid[%0d]", tag, k), out_valid, 1);
            check($sformatf("%s chan[%0d]", tag, k), out_chan, k);
            check($sformatf("%s data[%0d]", tag, k), out_data, exp_cnt[k]);
            check($sformatf("%s sat[%0d]", tag, k), out_sat, exp_sat[k]);
            check($sformatf("%s data4[%0d]", tag, k), out_data4, exp_cnt4[k]);
            check($sformatf("%s sat4[%0d]", tag, k), out_sat4, exp_sat4[k]);
            tick();
        end
        out_ready = 1'b0;
        check({tag, " end_busy"}, busy, 0);
        check({tag, " end_valid"}, out_valid, 0);
    endtask

    initial begin
        int hs;
        int cyc;
        logic stalled_prev;
        logic [AW-1:0] prev_chan;
        logic [15:0] prev_data;

        reset       = 1'b1;
        enable      = 1'b0;
        sig_in      = 8'hFF;
        wgt_we      = 1'b0;
        wgt_addr    = '0;
        wgt_data    = '0;
        dump_start  = 1'b0;
        clr_on_dump = 1'b0;
        out_ready   = 1'b0;

        // Reset with all nets high: nothing may count on release.
        repeat (5) tick();
        check("rst valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst chan", out_chan, 0);
        check("rst data", out_data, 0);
        check("rst sat", out_sat, 0);
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        clear_exp();
        do_dump("d_reset", 1'b0, '0);

        // Weight 3 on ch2, four rising edges -> 12.
        sig_in = '0;
        tick();
        write_wgt(2, 3);
        pulse(2, 4);
        clear_exp();
        exp_cnt[2]  = 12;
        exp_cnt4[2] = 12;
        do_dump("d_wgt3", 1'b1, '0);

        // Weight 5 on ch0 x4: 20 at 16 bits, saturates to 15 at 4 bits.
        // Weight 0 on ch3 and an edge on ch4 with enable low add nothing.
        write_wgt(0, 5);
        pulse(0, 4);
        write_wgt(3, 0);
        pulse(3, 1);
        enable = 1'b0;
        pulse(4, 1);
        enable = 1'b1;
        clear_exp();
        exp_cnt[0]  = 20;
        exp_cnt4[0] = 15;
        exp_sat4[0] = 1;
        do_dump("d_sat", 1'b1, '0);
        pulse(0, 1);
        clear_exp();
        exp_cnt[0]  = 5;
        exp_cnt4[0] = 5;
        do_dump("d_after_clr", 1'b0, '0);

        // Stalled dump, ready pattern 1,0,0 repeating; live ch0=5, ch5 gets 2.
        pulse(5, 2);
        clear_exp();
        exp_cnt[0] = 5;
        exp_cnt[5] = 2;
        dump_start = 1'b1;
        tick();
        dump_start   = 1'b0;
        hs           = 0;
        cyc          = 0;
        stalled_prev = 1'b0;
        prev_chan    = '0;
        prev_data    = '0;
        while (hs < N_CH && cyc < 64) begin
            out_ready = ((cyc % 3) == 0);
            if (stalled_prev) begin
                check("stall chan_hold", out_chan, prev_chan);
                check("stall data_hold", out_data, prev_data);
            end
            if (out_valid) begin
                check($sformatf("stall chan[%0d]", hs), out_chan, hs);
                check($sformatf("stall data[%0d]", hs), out_data, exp_cnt[hs]);
                if (out_ready) hs++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_chan    = out_chan;
            prev_data    = out_data;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("stall handshakes", hs, N_CH);
        check("stall end_busy", busy, 0);
        check("stall end_valid", out_valid, 0);

        // Edge on ch1 coincident with a clearing dump_start.
        clear_exp();
        exp_cnt[0]  = 5;
        exp_cnt[5]  = 2;
        exp_cnt4[0] = 5;
        exp_cnt4[5] = 2;
        do_dump("d_coinc", 1'b1, 8'h02);
        sig_in = '0;
        clear_exp();
        exp_cnt[1]  = 1;
        exp_cnt4[1] = 1;
        do_dump("d_coinc_live", 1'b0, '0);

        // Reset while streaming at idx 3 aborts; the next dump restarts at ch0.
        pulse(6, 1);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        out_ready  = 1'b1;
        repeat (3) tick();
        check("abort idx3", out_chan, 3);
        reset     = 1'b1;
        out_ready = 1'b0;
        tick();
        check("abort valid", out_valid, 0);
        check("abort busy", busy, 0);
        check("abort chan", out_chan, 0);
        check("abort data", out_data, 0);
        reset = 1'b0;
        tick();
        clear_exp();
        do_dump("d_post_abort", 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
